// File: rtl/per_port_dispatcher_pkg.sv
// Shared types and constants for the per-port egress dispatcher.
package per_port_dispatcher_pkg;

    typedef enum logic [1:0] {
        IN_PKT_HEADER = 2'd0,
        IN_PKT_BODY   = 2'd1,
        IN_PKT_DROP   = 2'd2
    } state_t;

    localparam int unsigned C_TUSER_DST_POS_DEF = 24;

    // Ceiling log2; log2(1) = 0.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = 32'(i + 1);
        end
        return res;
    endfunction

    localparam int unsigned C_FIFO_DEPTH      = 4;
    localparam int unsigned C_FIFO_DEPTH_BITS = log2(C_FIFO_DEPTH);

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: o_dout shows the head whenever !o_empty.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_nearly_full
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int unsigned PW    = MAX_DEPTH_BITS;
    localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr          = i_wr_en && (r_count != CW'(DEPTH));
    assign w_rd          = i_rd_en && (r_count != '0);
    assign o_dout        = r_mem[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_nearly_full = (r_count >= CW'(DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/per_port_dispatcher.sv
// Routes whole AXI4-Stream packets to per-port outputs by the first-beat tuser mask;
// supports multicast and drops (and counts) zero-mask packets.
module per_port_dispatcher
    import per_port_dispatcher_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_M_NUM_QUEUES       = 5,
    parameter int unsigned C_TUSER_DST_POS      = C_TUSER_DST_POS_DEF
) (
    input  logic                                                axi_aclk,
    input  logic                                                axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]                      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]                    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]                     s_axis_tuser,
    input  logic                                                s_axis_tvalid,
    output logic                                                s_axis_tready,
    input  logic                                                s_axis_tlast,
    output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_grp,
    output logic [C_M_NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb_grp,
    output logic [C_M_NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_grp,
    output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tvalid_grp,
    input  logic [C_M_NUM_QUEUES-1:0]                           m_axis_tready_grp,
    output logic [C_M_NUM_QUEUES-1:0]                           m_axis_tlast_grp,
    input  logic                                                sw_rst,
    output logic [31:0]                                         drop_count
);

    localparam int unsigned NQ = C_M_NUM_QUEUES;
    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned FW = 1 + UW + SW + DW;

    logic [FW-1:0] w_fifo_din;
    logic [FW-1:0] w_fifo_dout;
    logic          w_empty;
    logic          w_nearly_full;
    logic          w_wr_en;
    logic          w_pop;

    logic [DW-1:0] w_head_data;
    logic [SW-1:0] w_head_strb;
    logic [UW-1:0] w_head_user;
    logic          w_head_last;
    logic [NQ-1:0] w_head_mask;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [NQ-1:0] r_dst;
    logic [NQ-1:0] w_dst_nxt;
    logic [NQ-1:0] r_sent;
    logic [NQ-1:0] w_sent_nxt;
    logic [31:0]   r_drop_count;
    logic          w_drop;

    logic [NQ-1:0] w_active;
    logic          w_beat_live;
    logic [NQ-1:0] w_valid;
    logic [NQ-1:0] w_hs;
    logic          w_beat_done;

    assign w_fifo_din    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    assign s_axis_tready = !w_nearly_full;
    assign w_wr_en       = s_axis_tvalid && s_axis_tready;

    fallthrough_small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .i_clk         (axi_aclk),
        .i_rst_n       (axi_aresetn),
        .i_srst        (sw_rst),
        .i_din         (w_fifo_din),
        .i_wr_en       (w_wr_en),
        .i_rd_en       (w_pop),
        .o_dout        (w_fifo_dout),
        .o_empty       (w_empty),
        .o_nearly_full (w_nearly_full)
    );

    assign {w_head_last, w_head_user, w_head_strb, w_head_data} = w_fifo_dout;
    assign w_head_mask = w_head_user[C_TUSER_DST_POS +: NQ];

    // The header beat routes by its own mask; later beats reuse the latched one.
    assign w_active    = (r_state == IN_PKT_HEADER) ? w_head_mask : r_dst;
    assign w_beat_live = !w_empty && (r_state != IN_PKT_DROP) && (w_active != '0);
    assign w_valid     = w_beat_live ? (w_active & ~r_sent) : '0;
    assign w_hs        = w_valid & m_axis_tready_grp;
    assign w_beat_done = w_beat_live && (((r_sent | w_hs) & w_active) == w_active);

    // Next-state, pop and bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_dst_nxt   = r_dst;
        w_sent_nxt  = r_sent | w_hs;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        if (!w_empty) begin
            case (r_state)
                IN_PKT_HEADER: begin
                    if (w_head_mask == '0) begin
                        w_pop  = 1'b1;
                        w_drop = 1'b1;
                        if (!w_head_last) w_state_nxt = IN_PKT_DROP;
                    end else begin
                        w_dst_nxt = w_head_mask;
                        if (w_beat_done) begin
                            w_pop      = 1'b1;
                            w_sent_nxt = '0;
                            if (!w_head_last) w_state_nxt = IN_PKT_BODY;
                        end
                    end
                end
                IN_PKT_BODY: begin
                    if (w_beat_done) begin
                        w_pop      = 1'b1;
                        w_sent_nxt = '0;
                        if (w_head_last) w_state_nxt = IN_PKT_HEADER;
                    end
                end
                IN_PKT_DROP: begin
                    w_pop = 1'b1;
                    if (w_head_last) w_state_nxt = IN_PKT_HEADER;
                end
                default: w_state_nxt = IN_PKT_HEADER;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= IN_PKT_HEADER;
            r_dst        <= '0;
            r_sent       <= '0;
            r_drop_count <= '0;
        end else if (sw_rst) begin
            r_state      <= IN_PKT_HEADER;
            r_dst        <= '0;
            r_sent       <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dst   <= w_dst_nxt;
            r_sent  <= w_sent_nxt;
            if (w_drop) r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign m_axis_tdata_grp  = {C_M_NUM_QUEUES{w_head_data}};
    assign m_axis_tstrb_grp  = {C_M_NUM_QUEUES{w_head_strb}};
    assign m_axis_tuser_grp  = {C_M_NUM_QUEUES{w_head_user}};
    assign m_axis_tlast_grp  = {C_M_NUM_QUEUES{w_head_last}};
    assign m_axis_tvalid_grp = w_valid;
    assign drop_count        = r_drop_count;

endmodule

// File: tb/tb_per_port_dispatcher.sv
// Scoreboard bench for per_port_dispatcher: per-port expected-beat queues filled at
// input acceptance, drained by an output monitor; directed cases plus random traffic.
module tb_per_port_dispatcher;

    localparam int unsigned NQ  = 5;
    localparam int unsigned DW  = 256;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned UW  = 128;
    localparam int unsigned POS = 24;
    localparam int unsigned FW  = 1 + UW + SW + DW;

    typedef logic [FW-1:0] word_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sw_rst = 1'b0;
    logic [DW-1:0]        s_axis_tdata = '0;
    logic [SW-1:0]        s_axis_tstrb = '0;
    logic [UW-1:0]        s_axis_tuser = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic                 s_axis_tlast = 1'b0;
    logic [NQ*DW-1:0]     m_axis_tdata_grp;
    logic [NQ*SW-1:0]     m_axis_tstrb_grp;
    logic [NQ*UW-1:0]     m_axis_tuser_grp;
    logic [NQ-1:0]        m_axis_tvalid_grp;
    logic [NQ-1:0]        m_axis_tready_grp = '0;
    logic [NQ-1:0]        m_axis_tlast_grp;
    logic [31:0]          drop_count;

    int    checks = 0;
    int    errors = 0;
    int    exp_drops = 0;
    bit    rand_ready = 1'b0;
    word_t exp_q [NQ][$];

    per_port_dispatcher #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_M_NUM_QUEUES       (NQ),
        .C_TUSER_DST_POS      (POS)
    ) dut (
        .axi_aclk          (clk),
        .axi_aresetn       (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tstrb      (s_axis_tstrb),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .m_axis_tdata_grp  (m_axis_tdata_grp),
        .m_axis_tstrb_grp  (m_axis_tstrb_grp),
        .m_axis_tuser_grp  (m_axis_tuser_grp),
        .m_axis_tvalid_grp (m_axis_tvalid_grp),
        .m_axis_tready_grp (m_axis_tready_grp),
        .m_axis_tlast_grp  (m_axis_tlast_grp),
        .sw_rst            (sw_rst),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    function automatic word_t port_word(input int k);
        return {m_axis_tlast_grp[k], m_axis_tuser_grp[k*UW +: UW],
                m_axis_tstrb_grp[k*SW +: SW], m_axis_tdata_grp[k*DW +: DW]};
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int k = 0; k < NQ; k++) n += exp_q[k].size();
        return n;
    endfunction

    // Output monitor: every handshake must match the oldest expected beat of that port.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NQ; k++) begin
                if (m_axis_tvalid_grp[k] && m_axis_tready_grp[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat port %0d got %h", k, port_word(k));
                    end else begin
                        word_t e;
                        e = exp_q[k].pop_front();
                        if (port_word(k) !== e) begin
                            errors++;
                            $display("FAIL beat_port%0d got %h exp %h", k, port_word(k), e);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            for (int k = 0; k < NQ; k++) m_axis_tready_grp[k] = ($urandom_range(0, 9) < 7);
        end
    endtask

    // Offers one beat until accepted; on acceptance queues it for every port in dst.
    task automatic send_beat(input logic [NQ-1:0] dst, input logic [NQ-1:0] umask,
                             input logic last, output word_t w);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        bit            acc;
        int            n;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
        s = SW'($urandom);
        u[POS +: NQ] = umask;
        w = {last, u, s, d};
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tstrb  = s;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            acc = s_axis_tready;
            if (acc) begin
                for (int k = 0; k < NQ; k++) if (dst[k]) exp_q[k].push_back(w);
            end
            tick();
            n++;
            if (!acc && n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got 0 exp 1");
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [NQ-1:0] mask, input int nbeats, input int max_gap);
        word_t w;
        for (int i = 0; i < nbeats; i++) begin
            logic [NQ-1:0] um;
            um = (i == 0) ? mask : NQ'($urandom_range(1, 31));
            send_beat(mask, um, (i == nbeats - 1), w);
            if (i == 0 && mask == '0) exp_drops++;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pending() != 0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (8) tick();
        chk("drain_pending", 64'(pending()), 64'd0);
    endtask

    task automatic flush_model();
        for (int k = 0; k < NQ; k++) exp_q[k].delete();
        exp_drops = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w, b2;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tvalid", 64'(m_axis_tvalid_grp), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        chk("reset_tready", 64'(s_axis_tready), 64'd1);
        tick();

        // Unicast single-beat packet to port 2, visible one cycle after acceptance
        m_axis_tready_grp = '1;
        send_beat(5'b00100, 5'b00100, 1'b1, w);
        @(negedge clk);
        chk("unicast_tvalid", 64'(m_axis_tvalid_grp), 64'b00100);
        chk("unicast_tlast", 64'(m_axis_tlast_grp[2]), 64'd1);
        chk("unicast_drop_count", 64'(drop_count), 64'd0);
        drain();

        // Multicast to ports 0 and 2 with port 2 late
        m_axis_tready_grp = 5'b00001;
        send_beat(5'b00101, 5'b00101, 1'b1, w);
        @(negedge clk);
        chk("mcast_first_valid", 64'(m_axis_tvalid_grp), 64'b00101);
        tick();
        @(negedge clk);
        chk("mcast_port0_done", 64'(m_axis_tvalid_grp), 64'b00100);
        tick();
        tick();
        @(negedge clk);
        chk("mcast_held", 64'(m_axis_tvalid_grp), 64'b00100);
        chk("mcast_held_data", 64'(port_word(2) == w), 64'd1);
        m_axis_tready_grp = 5'b00101;
        tick();
        @(negedge clk);
        chk("mcast_popped", 64'(m_axis_tvalid_grp), 64'd0);
        drain();

        // Backpressure: port 0 stalls two cycles on beat 2 of 3
        m_axis_tready_grp = '1;
        send_beat(5'b00001, 5'b00001, 1'b0, w);
        send_beat(5'b00001, 5'b01000, 1'b0, b2);
        m_axis_tready_grp = '0;
        send_beat(5'b00001, 5'b00110, 1'b1, w);
        @(negedge clk);
        chk("bp_valid", 64'(m_axis_tvalid_grp), 64'b00001);
        chk("bp_held_beat2_a", 64'(port_word(0) == b2), 64'd1);
        tick();
        @(negedge clk);
        chk("bp_held_beat2_b", 64'(port_word(0) == b2), 64'd1);
        m_axis_tready_grp = '1;
        drain();

        // Body mask ignored: header to port 0, beat 2 carries mask 10000
        send_beat(5'b00001, 5'b00001, 1'b0, w);
        send_beat(5'b00001, 5'b10000, 1'b0, w);
        send_beat(5'b00001, 5'b00011, 1'b1, w);
        drain();

        // Drop a 4-beat zero-mask packet, then deliver to port 1
        send_pkt(5'b00000, 4, 0);
        send_pkt(5'b00010, 2, 0);
        drain();
        chk("drop_count_after_drop", 64'(drop_count), 64'(exp_drops));

        // sw_rst mid-packet with two beats stuck in the FIFO
        m_axis_tready_grp = '0;
        send_beat(5'b01010, 5'b01010, 1'b0, w);
        send_beat(5'b01010, 5'b00001, 1'b0, w);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        flush_model();
        m_axis_tready_grp = '1;
        @(negedge clk);
        chk("swrst_tvalid", 64'(m_axis_tvalid_grp), 64'd0);
        chk("swrst_drop_count", 64'(drop_count), 64'd0);
        tick();
        send_pkt(5'b00100, 2, 0);
        send_pkt(5'b00000, 1, 0);
        drain();
        chk("swrst_then_drop", 64'(drop_count), 64'(exp_drops));

        // axi_aresetn mid-packet
        m_axis_tready_grp = '0;
        send_beat(5'b10001, 5'b10001, 1'b0, w);
        send_beat(5'b10001, 5'b00010, 1'b0, w);
        rst_n = 1'b0;
        flush_model();
        @(negedge clk);
        chk("arst_tvalid_async", 64'(m_axis_tvalid_grp), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        m_axis_tready_grp = '1;
        @(negedge clk);
        chk("arst_tvalid", 64'(m_axis_tvalid_grp), 64'd0);
        chk("arst_drop_count", 64'(drop_count), 64'd0);
        chk("arst_tready", 64'(s_axis_tready), 64'd1);
        tick();
        send_pkt(5'b01000, 3, 0);
        drain();

        // Random traffic with random per-port backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 80; p++) begin
            logic [NQ-1:0] m;
            m = ($urandom_range(0, 5) == 0) ? '0 : NQ'($urandom_range(1, 31));
            send_pkt(m, $urandom_range(1, 5), 2);
        end
        drain();
        rand_ready = 1'b0;
        chk("random_drop_count", 64'(drop_count), 64'(exp_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
